// File: rtl/player_pkg.sv
// Shared player types and constants: direction codes from the input stage,
// movement states and playfield geometry.
package player_pkg;

   localparam int unsigned SCREEN_W = 96;
   localparam int unsigned SCREEN_H = 64;
   localparam int unsigned X_W      = 7;
   localparam int unsigned Y_W      = 6;

   // Horizontal and vertical codes share encodings; 2'b11 is treated as none.
   localparam logic [1:0] DIR_NULL  = 2'b00;
   localparam logic [1:0] DIR_LEFT  = 2'b01;
   localparam logic [1:0] DIR_RIGHT = 2'b10;
   localparam logic [1:0] DIR_UP    = 2'b01;
   localparam logic [1:0] DIR_DOWN  = 2'b10;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_MOVE_SLOW = 2'd1;
   localparam logic [1:0] ST_MOVE_FAST = 2'd2;

   typedef struct packed {
      logic [1:0] hor;
      logic [1:0] vert;
   } dir_t;

   function automatic logic [1:0] dir_norm(input logic [1:0] code);
      return (code == 2'b11) ? DIR_NULL : code;
   endfunction

endpackage

// File: rtl/move_tick_gen.sv
// Step-interval counter: counts while running, strobes expire_c on the last
// cycle of the selected (slow/fast) interval, then restarts from zero.
module move_tick_gen #(
   parameter int unsigned SLOW_DIV = 2000000,
   parameter int unsigned FAST_DIV = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic run,
   input  logic fast,
   output logic expire_c
);

   localparam int unsigned MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
   localparam int unsigned CNT_W   = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] limit;

   always_comb begin
      limit    = fast ? CNT_W'(FAST_DIV - 1) : CNT_W'(SLOW_DIV - 1);
      expire_c = run && (count == limit);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear || !run || expire_c) begin
         count <= '0;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/player_position_ctrl.sv
// Integrates debounced direction codes into the player's top-left position
// with slow-then-fast stepping. Build option PLAYER_WRAP_AROUND_EN wraps at
// screen edges instead of clamping.
module player_position_ctrl
   import player_pkg::*;
#(
   parameter int unsigned PLAYER_W    = 8,
   parameter int unsigned PLAYER_H    = 8,
   parameter int unsigned START_X     = 44,
   parameter int unsigned START_Y     = 28,
   parameter int unsigned SLOW_DIV    = 2000000,
   parameter int unsigned FAST_DIV    = 1000000,
   parameter int unsigned ACCEL_STEPS = 8
) (
   input  logic           clock_100mhz,
   input  logic           reset_n,
   input  logic           game_active,
   input  logic [1:0]     input_hor,
   input  logic [1:0]     input_vert,
   output logic [X_W-1:0] player_x,
   output logic [Y_W-1:0] player_y,
   output logic           moving,
   output logic           step_pulse
);

   localparam int unsigned X_MAX  = SCREEN_W - PLAYER_W;
   localparam int unsigned Y_MAX  = SCREEN_H - PLAYER_H;
   localparam int unsigned XS_W   = X_W + 1;
   localparam int unsigned YS_W   = Y_W + 1;
   localparam int unsigned STEP_W = $clog2(ACCEL_STEPS + 1);

   logic [1:0]        state;
   logic [1:0]        state_n;
   dir_t              dir_in;
   dir_t              dir_lat;
   dir_t              dir_n;
   logic [STEP_W-1:0] step_cnt;
   logic [STEP_W-1:0] step_n;
   logic [STEP_W-1:0] step_inc;
   logic              in_null;
   logic              do_step;
   logic              restart;
   logic              tick_clear;
   logic              tick_expire_c;
   logic [XS_W-1:0]   x_sum;
   logic [YS_W-1:0]   y_sum;
   logic [X_W-1:0]    x_n;
   logic [Y_W-1:0]    y_n;
   logic              pulse_n;

   move_tick_gen #(
      .SLOW_DIV (SLOW_DIV),
      .FAST_DIV (FAST_DIV)
   ) u_tick (
      .clk      (clock_100mhz),
      .rst_n    (reset_n),
      .clear    (tick_clear),
      .run      (state != ST_IDLE),
      .fast     (state == ST_MOVE_FAST),
      .expire_c (tick_expire_c)
   );

   always_comb begin
      dir_in.hor  = dir_norm(input_hor);
      dir_in.vert = dir_norm(input_vert);
      in_null     = (dir_in.hor == DIR_NULL) && (dir_in.vert == DIR_NULL);
      step_inc    = (step_cnt >= STEP_W'(ACCEL_STEPS)) ? STEP_W'(ACCEL_STEPS)
                                                       : step_cnt + STEP_W'(1);
   end

   // Next-state logic; a direction change outranks a same-cycle interval expiry.
   always_comb begin
      state_n    = state;
      dir_n      = dir_lat;
      step_n     = step_cnt;
      do_step    = 1'b0;
      restart    = 1'b0;
      tick_clear = 1'b0;

      if (!game_active) begin
         restart    = 1'b1;
         state_n    = ST_IDLE;
         dir_n      = '0;
         step_n     = '0;
         tick_clear = 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!in_null) begin
                  do_step    = 1'b1;
                  dir_n      = dir_in;
                  step_n     = STEP_W'(1);
                  tick_clear = 1'b1;
                  state_n    = ST_MOVE_SLOW;
               end
            end
            ST_MOVE_SLOW, ST_MOVE_FAST: begin
               if (in_null) begin
                  state_n    = ST_IDLE;
                  step_n     = '0;
                  tick_clear = 1'b1;
               end else if (dir_in != dir_lat) begin
                  do_step    = 1'b1;
                  dir_n      = dir_in;
                  step_n     = STEP_W'(1);
                  tick_clear = 1'b1;
                  state_n    = ST_MOVE_SLOW;
               end else if (tick_expire_c) begin
                  do_step = 1'b1;
                  step_n  = step_inc;
                  if (step_inc >= STEP_W'(ACCEL_STEPS)) begin
                     state_n = ST_MOVE_FAST;
                  end
               end
            end
            default: begin
               state_n    = ST_IDLE;
               step_n     = '0;
               tick_clear = 1'b1;
            end
         endcase
      end
   end

   // One signed guard bit per axis exposes underflow below zero.
   always_comb begin
      case (dir_n.hor)
         DIR_LEFT:  x_sum = {1'b0, player_x} - XS_W'(1);
         DIR_RIGHT: x_sum = {1'b0, player_x} + XS_W'(1);
         default:   x_sum = {1'b0, player_x};
      endcase
      case (dir_n.vert)
         DIR_UP:    y_sum = {1'b0, player_y} - YS_W'(1);
         DIR_DOWN:  y_sum = {1'b0, player_y} + YS_W'(1);
         default:   y_sum = {1'b0, player_y};
      endcase

`ifdef PLAYER_WRAP_AROUND_EN
      if (x_sum[X_W])                  x_n = X_W'(X_MAX);
      else if (x_sum > XS_W'(X_MAX))   x_n = '0;
      else                             x_n = x_sum[X_W-1:0];
      if (y_sum[Y_W])                  y_n = Y_W'(Y_MAX);
      else if (y_sum > YS_W'(Y_MAX))   y_n = '0;
      else                             y_n = y_sum[Y_W-1:0];
      pulse_n = do_step;
`else
      if (x_sum[X_W])                  x_n = '0;
      else if (x_sum > XS_W'(X_MAX))   x_n = X_W'(X_MAX);
      else                             x_n = x_sum[X_W-1:0];
      if (y_sum[Y_W])                  y_n = '0;
      else if (y_sum > YS_W'(Y_MAX))   y_n = Y_W'(Y_MAX);
      else                             y_n = y_sum[Y_W-1:0];
      pulse_n = do_step && ((x_n != player_x) || (y_n != player_y));
`endif
   end

   always_ff @(posedge clock_100mhz or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         dir_lat  <= '0;
         step_cnt <= '0;
      end else begin
         state    <= state_n;
         dir_lat  <= dir_n;
         step_cnt <= step_n;
      end
   end

   always_ff @(posedge clock_100mhz or negedge reset_n) begin
      if (!reset_n) begin
         player_x   <= X_W'(START_X);
         player_y   <= Y_W'(START_Y);
         moving     <= 1'b0;
         step_pulse <= 1'b0;
      end else begin
         moving <= (state_n != ST_IDLE);
         if (restart) begin
            player_x   <= X_W'(START_X);
            player_y   <= Y_W'(START_Y);
            step_pulse <= 1'b0;
         end else begin
            step_pulse <= pulse_n;
            if (do_step) begin
               player_x <= x_n;
               player_y <= y_n;
            end
         end
      end
   end

endmodule
